bfly_12_post_reorder: RTL

// - Downstream of the stage-1/2 butterfly + twiddle multiply. Consumes its 16 products/beat (8 low + 8 high lanes, 2.7 twiddle scaling).
// - Rounds off the 7 fractional bits and saturates to the next stage's input width.
// - Re-pairs samples 16 apart across consecutive beats, giving the next butterfly stage 8-lane din1/din2 vectors at 16 samples/beat.

---
 rtl/fft_pkg.sv | 15 +
 rtl/round_sat.sv | 35 +++
 rtl/bfly_12_post_reorder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_pkg: shared widths and frame constants for the FFT datapath      |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
package fft_pkg;

    localparam int c_out_bit     = 14;
    localparam int c_frac        = 7;
    localparam int c_frame_beats = 32;

    typedef logic signed [c_out_bit-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_sat: one lane, round-half-up by FRAC bits then clamp to OUT_BIT|
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module round_sat
    import fft_pkg::*;
#(
    parameter int IN_BIT  = 25,
    parameter int FRAC    = c_frac,
    parameter int OUT_BIT = c_out_bit
) (
    input  logic [IN_BIT-1:0]  x,
    output logic [OUT_BIT-1:0] y,
    output logic               sat
);

    localparam int                 c_sw   = IN_BIT + 1;
    localparam logic [c_sw-1:0]    c_half = c_sw'(1) << (FRAC - 1);
    localparam logic [OUT_BIT-1:0] c_max  = {1'b0, {(OUT_BIT-1){1'b1}}};
    localparam logic [OUT_BIT-1:0] c_min  = {1'b1, {(OUT_BIT-1){1'b0}}};

    logic [c_sw-1:0]           w_sum;
    logic signed [c_sw-1:0]    w_shr;
    logic [c_sw-OUT_BIT:0]     w_hi;

    // One guard bit keeps the +half from wrapping at the positive extreme.
    assign w_sum = {x[IN_BIT-1], x} + c_half;
    assign w_shr = $signed(w_sum) >>> FRAC;
    assign w_hi  = w_shr[c_sw-1:OUT_BIT-1];
    assign sat   = ~((&w_hi) | ~(|w_hi));
    assign y     = sat ? (w_shr[c_sw-1] ? c_min : c_max) : w_shr[OUT_BIT-1:0];

endmodule
`default_nettype wire

// File: rtl/bfly_12_post_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bfly_12_post_reorder: round/saturate products, re-pair beats 16 apart|
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module bfly_12_post_reorder
    import fft_pkg::*;
#(
    parameter int N           = 8,
    parameter int IN_BIT      = 25,
    parameter int FRAC        = c_frac,
    parameter int OUT_BIT     = c_out_bit,
    parameter int FRAME_BEATS = c_frame_beats
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    input  logic [N-1:0][IN_BIT-1:0]  din_lo_i,
    input  logic [N-1:0][IN_BIT-1:0]  din_lo_q,
    input  logic [N-1:0][IN_BIT-1:0]  din_hi_i,
    input  logic [N-1:0][IN_BIT-1:0]  din_hi_q,
    output logic [N-1:0][OUT_BIT-1:0] dout1_i,
    output logic [N-1:0][OUT_BIT-1:0] dout1_q,
    output logic [N-1:0][OUT_BIT-1:0] dout2_i,
    output logic [N-1:0][OUT_BIT-1:0] dout2_q,
    output logic                      out_valid,
    output logic                      out_first,
    output logic                      sat_flag
);

    localparam int c_cnt_w = (FRAME_BEATS > 2) ? $clog2(FRAME_BEATS) : 1;

    // Quadrant order everywhere: 0 lo_i, 1 lo_q, 2 hi_i, 3 hi_q.
    logic [3:0][N-1:0][IN_BIT-1:0]  w_x;
    logic [3:0][N-1:0][OUT_BIT-1:0] w_y;
    logic [4*N-1:0]                 w_sat;
    logic                           w_cnt_last;

    logic [3:0][N-1:0][OUT_BIT-1:0] r_rnd;
    logic [3:0][N-1:0][OUT_BIT-1:0] r_dly;
    logic [3:0][N-1:0][OUT_BIT-1:0] r_a;
    logic [1:0][N-1:0][OUT_BIT-1:0] r_b2;
    logic                           r_rnd_vld, r_rnd_odd, r_rnd_first;
    logic                           r_dly_vld, r_dly_odd, r_dly_first;
    logic                           r_phase;
    logic                           r_pend;
    logic [c_cnt_w-1:0]             r_cnt;

    assign w_x        = {din_hi_q, din_hi_i, din_lo_q, din_lo_i};
    assign w_cnt_last = (r_cnt == c_cnt_w'(FRAME_BEATS - 1));

    for (genvar q = 0; q < 4; q++) begin : g_quad
        for (genvar k = 0; k < N; k++) begin : g_lane
            round_sat #(
                .IN_BIT  (IN_BIT),
                .FRAC    (FRAC),
                .OUT_BIT (OUT_BIT)
            ) u_round_sat (
                .x   (w_x[q][k]),
                .y   (w_y[q][k]),
                .sat (w_sat[q*N+k])
            );
        end
    end

    // Stage R plus beat parity / frame position, tagged onto each beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rnd       <= '0;
            r_rnd_vld   <= 1'b0;
            r_rnd_odd   <= 1'b0;
            r_rnd_first <= 1'b0;
            r_phase     <= 1'b0;
            r_cnt       <= '0;
            sat_flag    <= 1'b0;
        end else begin
            r_rnd_vld <= in_valid;
            if (in_valid) begin
                r_rnd       <= w_y;
                r_rnd_odd   <= r_phase;
                r_rnd_first <= (r_cnt == c_cnt_w'(1));
                r_phase     <= ~r_phase;
                r_cnt       <= w_cnt_last ? '0 : r_cnt + c_cnt_w'(1);
                if (|w_sat) begin
                    sat_flag <= 1'b1;
                end
            end else begin
                r_phase <= 1'b0;
                r_cnt   <= '0;
            end
        end
    end

    // Alignment stage so a pair emerges two edges after its odd beat is sampled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dly       <= '0;
            r_dly_vld   <= 1'b0;
            r_dly_odd   <= 1'b0;
            r_dly_first <= 1'b0;
        end else begin
            r_dly_vld <= r_rnd_vld;
            if (r_rnd_vld) begin
                r_dly       <= r_rnd;
                r_dly_odd   <= r_rnd_odd;
                r_dly_first <= r_rnd_first;
            end
        end
    end

    // Odd beats are never back to back, so a pair and a pend output cannot collide.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a       <= '0;
            r_b2      <= '0;
            r_pend    <= 1'b0;
            dout1_i   <= '0;
            dout1_q   <= '0;
            dout2_i   <= '0;
            dout2_q   <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            if (r_dly_vld && !r_dly_odd) begin
                r_a <= r_dly;
            end
            if (r_dly_vld && r_dly_odd) begin
                dout1_i   <= r_a[0];
                dout1_q   <= r_a[1];
                dout2_i   <= r_dly[0];
                dout2_q   <= r_dly[1];
                r_b2      <= {r_dly[3], r_dly[2]};
                r_pend    <= 1'b1;
                out_valid <= 1'b1;
                out_first <= r_dly_first;
            end else if (r_pend) begin
                dout1_i   <= r_a[2];
                dout1_q   <= r_a[3];
                dout2_i   <= r_b2[0];
                dout2_q   <= r_b2[1];
                r_pend    <= 1'b0;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
